// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit single-cycle CPU: word and index widths,
// instruction field positions and default storage depths.
package cpu16_pkg;

   localparam int WORD_W    = 16;
   localparam int REG_IDX_W = 3;

   localparam int OPC_HI   = 15;
   localparam int OPC_LO   = 14;
   localparam int RS_HI    = 13;
   localparam int RS_LO    = 11;
   localparam int RT_HI    = 10;
   localparam int RT_LO    = 8;
   localparam int RD_HI    = 7;
   localparam int RD_LO    = 5;
   localparam int FUNCT_HI = 4;
   localparam int FUNCT_LO = 0;
   localparam int IMM_HI   = 7;
   localparam int IMM_LO   = 0;

   localparam int IMEM_DEPTH_DEF = 64;
   localparam int DMEM_DEPTH_DEF = 128;
   localparam int NREGS_DEF      = 8;

   typedef logic [WORD_W-1:0]    word_t;
   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   // R-type view of an instruction word; imm overlays rd/funct for I-type.
   typedef struct packed {
      logic [OPC_HI-OPC_LO:0]     opcode;
      reg_idx_t                   rs;
      reg_idx_t                   rt;
      reg_idx_t                   rd;
      logic [FUNCT_HI-FUNCT_LO:0] funct;
   } instr_fields_t;

   function automatic logic is_zero_reg(input reg_idx_t idx);
      return idx == '0;
   endfunction

endpackage

// File: rtl/cpu16_storage_if.sv
// Bus between the CPU datapath (master) and the storage subsystem (slave).
interface cpu16_storage_if #(
   parameter int IMEM_DEPTH = 64,
   parameter int DMEM_DEPTH = 128
);
   import cpu16_pkg::*;

   localparam int IMEM_AW = $clog2(IMEM_DEPTH);

   // No handshake: every *_we / mem_write is sampled at the rising clk edge,
   // and every read output is a pure combinational function of its address.
   word_t               pc;
   word_t               instr;
   logic                imem_we;
   logic [IMEM_AW-1:0]  imem_waddr;
   word_t               imem_wdata;

   reg_idx_t            rs;
   reg_idx_t            rt;
   reg_idx_t            rd;
   word_t               wd;
   logic                rf_we;
   word_t               rd1;
   word_t               rd2;

   word_t               dmem_addr;
   word_t               dmem_wdata;
   logic                mem_write;
   logic                mem_read;
   word_t               dmem_rdata;

   modport master (
      output pc, imem_we, imem_waddr, imem_wdata,
      output rs, rt, rd, wd, rf_we,
      output dmem_addr, dmem_wdata, mem_write, mem_read,
      input  instr, rd1, rd2, dmem_rdata
   );

   modport slave (
      input  pc, imem_we, imem_waddr, imem_wdata,
      input  rs, rt, rd, wd, rf_we,
      input  dmem_addr, dmem_wdata, mem_write, mem_read,
      output instr, rd1, rd2, dmem_rdata
   );

endinterface

// File: rtl/cpu16_ram_array.sv
// Word array with one synchronous write port, NRD combinational read ports
// and an asynchronous clear of every word.
module cpu16_ram_array
   import cpu16_pkg::*;
#(
   parameter  int DEPTH = 8,
   parameter  int WIDTH = WORD_W,
   parameter  int NRD   = 1,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      we_i,
   input  logic [AW-1:0]             waddr_i,
   input  logic [WIDTH-1:0]          wdata_i,
   input  logic [NRD-1:0][AW-1:0]    raddr_i,
   output logic [NRD-1:0][WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Reads see mem_q directly, so a same-edge read returns the old word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_comb begin
      rdata_o = '0;
      for (int p = 0; p < NRD; p++) begin
         rdata_o[p] = mem_q[raddr_i[p]];
      end
   end

endmodule

// File: rtl/cpu16_storage.sv
// Instruction memory, 8-entry register file and data memory of the
// single-cycle CPU: synchronous writes, combinational reads.
module cpu16_storage
   import cpu16_pkg::*;
#(
   parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
   parameter int DMEM_DEPTH = DMEM_DEPTH_DEF,
   parameter int NREGS      = NREGS_DEF
) (
   input  logic            clk,
   input  logic            reset,
   cpu16_storage_if.slave  bus
);

   localparam int IAW = $clog2(IMEM_DEPTH);
   localparam int DAW = $clog2(DMEM_DEPTH);
   localparam int RAW = $clog2(NREGS);

   logic [0:0][IAW-1:0]    imem_raddr;
   logic [0:0][WORD_W-1:0] imem_rdata;
   logic [1:0][RAW-1:0]    rf_raddr;
   logic [1:0][WORD_W-1:0] rf_rdata;
   logic [0:0][DAW-1:0]    dmem_raddr;
   logic [0:0][WORD_W-1:0] dmem_rdata;
   logic                   rf_we_gated;
   logic                   unused_addr_bits;

   // Upper address bits are dropped so fetch and data addresses alias.
   assign imem_raddr[0]    = bus.pc[IAW-1:0];
   assign dmem_raddr[0]    = bus.dmem_addr[DAW-1:0];
   assign rf_raddr[0]      = bus.rs[RAW-1:0];
   assign rf_raddr[1]      = bus.rt[RAW-1:0];
   assign rf_we_gated      = bus.rf_we && !is_zero_reg(bus.rd);
   assign unused_addr_bits = ^{bus.pc[WORD_W-1:IAW], bus.dmem_addr[WORD_W-1:DAW]};

   cpu16_ram_array #(.DEPTH(IMEM_DEPTH), .WIDTH(WORD_W), .NRD(1)) u_imem (
      .clk     (clk),
      .rst     (reset),
      .we_i    (bus.imem_we),
      .waddr_i (bus.imem_waddr),
      .wdata_i (bus.imem_wdata),
      .raddr_i (imem_raddr),
      .rdata_o (imem_rdata)
   );

   cpu16_ram_array #(.DEPTH(NREGS), .WIDTH(WORD_W), .NRD(2)) u_regfile (
      .clk     (clk),
      .rst     (reset),
      .we_i    (rf_we_gated),
      .waddr_i (bus.rd[RAW-1:0]),
      .wdata_i (bus.wd),
      .raddr_i (rf_raddr),
      .rdata_o (rf_rdata)
   );

   cpu16_ram_array #(.DEPTH(DMEM_DEPTH), .WIDTH(WORD_W), .NRD(1)) u_dmem (
      .clk     (clk),
      .rst     (reset),
      .we_i    (bus.mem_write),
      .waddr_i (bus.dmem_addr[DAW-1:0]),
      .wdata_i (bus.dmem_wdata),
      .raddr_i (dmem_raddr),
      .rdata_o (dmem_rdata)
   );

   // Register 0 is hard-wired to zero; reset forces every output to zero.
   always_comb begin
      bus.instr      = '0;
      bus.rd1        = '0;
      bus.rd2        = '0;
      bus.dmem_rdata = '0;
      if (!reset) begin
         bus.instr = imem_rdata[0];
         if (!is_zero_reg(bus.rs)) bus.rd1 = rf_rdata[0];
         if (!is_zero_reg(bus.rt)) bus.rd2 = rf_rdata[1];
         if (bus.mem_read)         bus.dmem_rdata = dmem_rdata[0];
      end
   end

endmodule

// File: tb/tb_cpu16_storage.sv
// Directed bench for cpu16_storage: read-vector table plus hand-written
// reset, read-during-write and write-enable sequences.
module tb_cpu16_storage;
   import cpu16_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   cpu16_storage_if bus ();

   cpu16_storage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [15:0] exp_q[$];

   typedef struct {
      logic [15:0] pc;
      logic [2:0]  rs;
      logic [2:0]  rt;
      logic [15:0] addr;
      logic        mrd;
      logic [15:0] e_instr;
      logic [15:0] e_rd1;
      logic [15:0] e_rd2;
      logic [15:0] e_dm;
   } vec_t;

   vec_t vecs[7];

   task automatic expect_val(input logic [15:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string name, input logic [15:0] act);
      logic [15:0] exp;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL %s: got %h but no expected value queued", name, act);
      end else begin
         exp = exp_q.pop_front();
         if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
         end
      end
   endtask

   task automatic idle();
      bus.imem_we    = 1'b0;
      bus.rf_we      = 1'b0;
      bus.mem_write  = 1'b0;
      bus.imem_waddr = '0;
      bus.imem_wdata = '0;
      bus.rd         = '0;
      bus.wd         = '0;
      bus.dmem_wdata = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_reg(input logic [2:0] idx, input logic [15:0] data);
      bus.rd = idx; bus.wd = data; bus.rf_we = 1'b1;
      step();
      bus.rf_we = 1'b0;
   endtask

   task automatic store(input logic [15:0] addr, input logic [15:0] data);
      bus.dmem_addr = addr; bus.dmem_wdata = data; bus.mem_write = 1'b1;
      step();
      bus.mem_write = 1'b0;
   endtask

   task automatic load_imem(input logic [5:0] addr, input logic [15:0] data);
      bus.imem_waddr = addr; bus.imem_wdata = data; bus.imem_we = 1'b1;
      step();
      bus.imem_we = 1'b0;
   endtask

   task automatic set_reads(input logic [15:0] pc, input logic [2:0] rs,
                            input logic [2:0] rt, input logic [15:0] addr,
                            input logic mrd);
      bus.pc = pc; bus.rs = rs; bus.rt = rt; bus.dmem_addr = addr; bus.mem_read = mrd;
      #1;
   endtask

   initial begin
      idle();
      set_reads(16'h0000, 3'd1, 3'd1, 16'h0001, 1'b1);

      // Reset held across edges with every write enable active.
      #1 reset = 1'b1;
      bus.rd = 3'd1; bus.wd = 16'hFFFF; bus.rf_we = 1'b1;
      bus.dmem_addr = 16'h0001; bus.dmem_wdata = 16'hFFFF; bus.mem_write = 1'b1;
      bus.imem_waddr = 6'd0; bus.imem_wdata = 16'hFFFF; bus.imem_we = 1'b1;
      step();
      step();
      expect_val(16'h0000); check("rst_instr", bus.instr);
      expect_val(16'h0000); check("rst_rd1", bus.rd1);
      expect_val(16'h0000); check("rst_dmem", bus.dmem_rdata);
      idle();
      #2 reset = 1'b0;
      expect_val(16'h0000); check("rst_write_ignored_rd1", bus.rd1);

      // First writes after reset, then a mid-cycle reset pulse.
      load_imem(6'd0, 16'h0A20);
      write_reg(3'd3, 16'h1234);
      store(16'd5, 16'hBEEF);
      set_reads(16'h0000, 3'd3, 3'd0, 16'd5, 1'b1);
      expect_val(16'h0A20); check("pre_rst_instr", bus.instr);
      expect_val(16'h1234); check("pre_rst_reg3", bus.rd1);
      expect_val(16'hBEEF); check("pre_rst_mem5", bus.dmem_rdata);

      bus.rd = 3'd3; bus.wd = 16'h5555; bus.rf_we = 1'b1;
      bus.dmem_wdata = 16'h7777; bus.mem_write = 1'b1;
      #1 reset = 1'b1;
      #1;
      expect_val(16'h0000); check("async_rst_reg3", bus.rd1);
      expect_val(16'h0000); check("async_rst_mem5", bus.dmem_rdata);
      expect_val(16'h0000); check("async_rst_instr", bus.instr);
      step();
      idle();
      #2 reset = 1'b0;
      #1;
      expect_val(16'h0000); check("rst_edge_discard_reg3", bus.rd1);
      expect_val(16'h0000); check("rst_edge_discard_mem5", bus.dmem_rdata);
      expect_val(16'h0000); check("rst_cleared_imem0", bus.instr);

      // Populate all three arrays for the read-vector table.
      load_imem(6'd0, 16'h0A20);
      load_imem(6'd1, 16'h4B05);
      load_imem(6'd2, 16'h8C01);
      load_imem(6'd3, 16'hC000);
      write_reg(3'd2, 16'hA5A5);
      write_reg(3'd7, 16'h0F0F);
      write_reg(3'd0, 16'hFFFF);
      store(16'd10, 16'h00FF);
      store(16'd3, 16'h1111);

      vecs[0] = '{16'h0000, 3'd2, 3'd7, 16'd10,   1'b1, 16'h0A20, 16'hA5A5, 16'h0F0F, 16'h00FF};
      vecs[1] = '{16'h0001, 3'd7, 3'd2, 16'd10,   1'b0, 16'h4B05, 16'h0F0F, 16'hA5A5, 16'h0000};
      vecs[2] = '{16'h0002, 3'd0, 3'd0, 16'd138,  1'b1, 16'h8C01, 16'h0000, 16'h0000, 16'h00FF};
      vecs[3] = '{16'h0003, 3'd2, 3'd2, 16'd3,    1'b1, 16'hC000, 16'hA5A5, 16'hA5A5, 16'h1111};
      vecs[4] = '{16'd64,   3'd3, 3'd7, 16'd131,  1'b1, 16'h0A20, 16'h0000, 16'h0F0F, 16'h1111};
      vecs[5] = '{16'hFFC1, 3'd1, 3'd0, 16'hFF8A, 1'b1, 16'h4B05, 16'h0000, 16'h0000, 16'h00FF};
      vecs[6] = '{16'h0005, 3'd7, 3'd3, 16'd5,    1'b1, 16'h0000, 16'h0F0F, 16'h0000, 16'h0000};

      for (int i = 0; i < 7; i++) begin
         set_reads(vecs[i].pc, vecs[i].rs, vecs[i].rt, vecs[i].addr, vecs[i].mrd);
         expect_val(vecs[i].e_instr); check($sformatf("vec%0d_instr", i), bus.instr);
         expect_val(vecs[i].e_rd1);   check($sformatf("vec%0d_rd1", i), bus.rd1);
         expect_val(vecs[i].e_rd2);   check($sformatf("vec%0d_rd2", i), bus.rd2);
         expect_val(vecs[i].e_dm);    check($sformatf("vec%0d_dmem", i), bus.dmem_rdata);
      end

      // Register read during write: old value before the edge, new after.
      set_reads(16'h0001, 3'd2, 3'd7, 16'd3, 1'b1);
      bus.rd = 3'd2; bus.wd = 16'h1357; bus.rf_we = 1'b1;
      #1;
      expect_val(16'hA5A5); check("rf_rdw_before", bus.rd1);
      step();
      bus.rf_we = 1'b0;
      expect_val(16'h1357); check("rf_rdw_after", bus.rd1);

      // Data memory read and write together at the same address.
      bus.dmem_wdata = 16'h2222; bus.mem_write = 1'b1;
      #1;
      expect_val(16'h1111); check("dm_rdw_before", bus.dmem_rdata);
      step();
      bus.mem_write = 1'b0;
      expect_val(16'h2222); check("dm_rdw_after", bus.dmem_rdata);

      // Instruction memory read during program-load write.
      bus.imem_waddr = 6'd1; bus.imem_wdata = 16'hBEEF; bus.imem_we = 1'b1;
      #1;
      expect_val(16'h4B05); check("im_rdw_before", bus.instr);
      step();
      bus.imem_we = 1'b0;
      expect_val(16'hBEEF); check("im_rdw_after", bus.instr);

      // Write data applied with every enable low over several edges.
      idle();
      bus.rd = 3'd7; bus.wd = 16'hDEAD;
      bus.dmem_wdata = 16'hDEAD;
      bus.imem_waddr = 6'd0; bus.imem_wdata = 16'hDEAD;
      set_reads(16'h0000, 3'd7, 3'd2, 16'd10, 1'b1);
      step();
      step();
      step();
      expect_val(16'h0F0F); check("gate_reg7", bus.rd1);
      expect_val(16'h1357); check("gate_reg2", bus.rd2);
      expect_val(16'h00FF); check("gate_mem10", bus.dmem_rdata);
      expect_val(16'h0A20); check("gate_imem0", bus.instr);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
